// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MIPS cache/write-buffer memory arbiter.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2
  } state_t;

  localparam int unsigned CH_INSTR   = 0;
  localparam int unsigned CH_DATA    = 1;

  localparam int unsigned PRIO_FIXED = 0;
  localparam int unsigned PRIO_RR    = 1;

endpackage

// File: rtl/mips_rr_arbiter.sv
// Fixed-priority or round-robin request arbiter with an eligibility mask;
// returns a one-hot grant and its binary index.
module mips_rr_arbiter import mips_mem_pkg::*; #(
  parameter int unsigned N       = 2,
  parameter int unsigned RR_MODE = PRIO_FIXED,
  localparam int unsigned PW     = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  input  logic [N-1:0]  en_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] idx_o
);

  logic [PW-1:0] cand;
  logic          found;

  // Scan from ptr_i (round-robin) or from 0 (fixed); first eligible request wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned o = 0; o < N; o++) begin
      cand = (RR_MODE == PRIO_RR) ? PW'((32'(ptr_i) + o) % N) : PW'(o);
      if (!found && req_i[cand] && en_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/mips_mem_arbiter.sv
// Arbitrates cache line refills and write-buffer drains onto one Avalon master,
// with critical-word-first wrap and a write-buffer high-water override.
module mips_mem_arbiter import mips_mem_pkg::*; #(
  parameter int unsigned NUM_RD        = 2,
  parameter int unsigned LINE_WORDS    = 4,
  parameter int unsigned WRAP_FILL     = 1,
  parameter int unsigned RR_MODE       = PRIO_FIXED,
  parameter int unsigned WB_DEPTH      = 8,
  parameter int unsigned WB_HIGH_WATER = 6,
  localparam int unsigned WW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1,
  localparam int unsigned LW = $clog2(WB_DEPTH + 1),
  localparam int unsigned PW = (NUM_RD > 1) ? $clog2(NUM_RD) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_RD-1:0]    rd_req,
  input  logic [32*NUM_RD-1:0] rd_addr,
  output logic [NUM_RD-1:0]    rd_valid,
  output logic [31:0]          rd_data,
  output logic [WW-1:0]        rd_word,
  output logic                 rd_last,
  input  logic                 wr_req,
  input  logic [31:0]          wr_addr,
  input  logic [31:0]          wr_data,
  input  logic [3:0]           wr_byteenable,
  input  logic [LW-1:0]        wb_level,
  output logic                 wr_ack,
  output logic [31:0]          mem_address,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [31:0]          mem_writedata,
  output logic [3:0]           mem_byteenable,
  input  logic                 waitrequest,
  input  logic [31:0]          mem_readdata,
  output logic                 busy
);

  localparam int unsigned  OFF      = $clog2(LINE_WORDS) + 2;
  localparam logic [31:0]  BASEMASK = ~((32'd1 << OFF) - 32'd1);
  localparam logic [WW-1:0] IDXMASK = WW'(LINE_WORDS - 1);

  state_t        state_q, state_d;
  logic [PW-1:0] g_q, g_d, rr_q, rr_d;
  logic [31:0]   base_q, base_d;
  logic [WW-1:0] s_q, s_d, k_q, k_d;

  logic [NUM_RD-1:0] en, gnt;
  logic [PW-1:0]     gidx;
  logic [31:0]       sel_addr;
  logic [WW-1:0]     widx;
  logic              last_word, hi_water;

  // A pending write hides the data channel so the buffer drains before any data refill.
  always_comb begin
    en = '1;
    if (wr_req) en[CH_DATA] = 1'b0;
  end

  mips_rr_arbiter #(
    .N       (NUM_RD),
    .RR_MODE (RR_MODE)
  ) u_arb (
    .req_i (rd_req),
    .ptr_i (rr_q),
    .en_i  (en),
    .gnt_o (gnt),
    .idx_o (gidx)
  );

  assign sel_addr  = rd_addr[32*int'(gidx) +: 32];
  assign widx      = (s_q + k_q) & IDXMASK;
  assign last_word = (k_q == IDXMASK);
  assign hi_water  = wr_req && (32'(wb_level) >= WB_HIGH_WATER);
  assign busy      = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    rr_d    = rr_q;
    base_d  = base_q;
    s_d     = s_q;
    k_d     = k_q;
    unique case (state_q)
      IDLE: begin
        if (hi_water) begin
          state_d = WRITE;
        end else if (|gnt) begin
          state_d = FILL;
          g_d     = gidx;
          base_d  = sel_addr & BASEMASK;
          s_d     = (WRAP_FILL != 0) ? (WW'(sel_addr >> 2) & IDXMASK) : '0;
          k_d     = '0;
        end else if (wr_req) begin
          state_d = WRITE;
        end
      end
      FILL: begin
        if (!waitrequest) begin
          k_d = k_q + WW'(1);
          if (last_word) begin
            state_d = IDLE;
            k_d     = '0;
            if (RR_MODE == PRIO_RR) rr_d = PW'((32'(g_q) + 1) % NUM_RD);
          end
        end
      end
      WRITE: begin
        if (!waitrequest) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobes are masked while reset is asserted so an aborted transfer is never reported.
  always_comb begin
    mem_address    = '0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_writedata  = '0;
    mem_byteenable = 4'b0000;
    rd_valid       = '0;
    rd_data        = '0;
    rd_word        = '0;
    rd_last        = 1'b0;
    wr_ack         = 1'b0;
    unique case (state_q)
      FILL: begin
        mem_read       = 1'b1;
        mem_byteenable = 4'b1111;
        mem_address    = base_q + 32'({widx, 2'b00});
        rd_word        = widx;
        if (!waitrequest && rst) begin
          rd_valid[g_q] = 1'b1;
          rd_data       = mem_readdata;
          rd_last       = last_word;
        end
      end
      WRITE: begin
        mem_write      = 1'b1;
        mem_address    = wr_addr;
        mem_writedata  = wr_data;
        mem_byteenable = wr_byteenable;
        wr_ack         = !waitrequest && rst;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      g_q     <= '0;
      rr_q    <= '0;
      base_q  <= '0;
      s_q     <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      rr_q    <= rr_d;
      base_q  <= base_d;
      s_q     <= s_d;
      k_q     <= k_d;
    end
  end

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed bench: instance A uses wrap fill + fixed priority, instance B linear fill + round-robin.
module tb_mips_mem_arbiter;

  localparam logic [31:0] RDX = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  rd_req;
  logic [63:0] rd_addr;
  logic        wr_req;
  logic [31:0] wr_addr, wr_data;
  logic [3:0]  wr_byteenable;
  logic [3:0]  wb_level;
  logic        waitrequest;

  logic [1:0]  rd_valid_a, rd_valid_b;
  logic [31:0] rd_data_a, rd_data_b;
  logic [1:0]  rd_word_a, rd_word_b;
  logic        rd_last_a, rd_last_b, wr_ack_a, wr_ack_b;
  logic [31:0] mem_address_a, mem_address_b, mem_writedata_a, mem_writedata_b;
  logic        mem_read_a, mem_read_b, mem_write_a, mem_write_b, busy_a, busy_b;
  logic [3:0]  mem_byteenable_a, mem_byteenable_b;
  logic [31:0] mem_readdata_a, mem_readdata_b;

  int n_checks = 0;
  int n_errors = 0;
  int ack_cnt  = 0;
  int last_cnt = 0;
  int ack0, last0;

  always #5 clk = ~clk;

  // Memory returns a word derived from its address.
  assign mem_readdata_a = mem_address_a ^ RDX;
  assign mem_readdata_b = mem_address_b ^ RDX;

  always @(negedge clk) begin
    if (wr_ack_a)  ack_cnt  <= ack_cnt + 1;
    if (rd_last_a) last_cnt <= last_cnt + 1;
  end

  mips_mem_arbiter u_dut_a (
    .clk (clk), .rst (rst), .rd_req (rd_req), .rd_addr (rd_addr),
    .rd_valid (rd_valid_a), .rd_data (rd_data_a), .rd_word (rd_word_a), .rd_last (rd_last_a),
    .wr_req (wr_req), .wr_addr (wr_addr), .wr_data (wr_data), .wr_byteenable (wr_byteenable),
    .wb_level (wb_level), .wr_ack (wr_ack_a), .mem_address (mem_address_a),
    .mem_read (mem_read_a), .mem_write (mem_write_a), .mem_writedata (mem_writedata_a),
    .mem_byteenable (mem_byteenable_a), .waitrequest (waitrequest),
    .mem_readdata (mem_readdata_a), .busy (busy_a)
  );

  mips_mem_arbiter #(
    .WRAP_FILL (0),
    .RR_MODE   (1)
  ) u_dut_b (
    .clk (clk), .rst (rst), .rd_req (rd_req), .rd_addr (rd_addr),
    .rd_valid (rd_valid_b), .rd_data (rd_data_b), .rd_word (rd_word_b), .rd_last (rd_last_b),
    .wr_req (wr_req), .wr_addr (wr_addr), .wr_data (wr_data), .wr_byteenable (wr_byteenable),
    .wb_level (wb_level), .wr_ack (wr_ack_b), .mem_address (mem_address_b),
    .mem_read (mem_read_b), .mem_write (mem_write_b), .mem_writedata (mem_writedata_b),
    .mem_byteenable (mem_byteenable_b), .waitrequest (waitrequest),
    .mem_readdata (mem_readdata_b), .busy (busy_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0; rd_req = '0; rd_addr = '0; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    wr_byteenable = '0; wb_level = '0; waitrequest = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] idx;
    logic [31:0] exp_addr;

    rst = 1'b0; rd_req = '0; rd_addr = '0; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    wr_byteenable = '0; wb_level = '0; waitrequest = 1'b0;

    // Reset state
    do_reset();
    @(negedge clk);
    check("rst_mem_read", 32'(mem_read_a), 0);
    check("rst_mem_write", 32'(mem_write_a), 0);
    check("rst_rd_valid", 32'(rd_valid_a), 0);
    check("rst_rd_last", 32'(rd_last_a), 0);
    check("rst_wr_ack", 32'(wr_ack_a), 0);
    check("rst_busy", 32'(busy_a), 0);
    check("rst_mem_address", mem_address_a, 0);
    check("rst_writedata", mem_writedata_a, 0);
    check("rst_rd_data", rd_data_a, 0);
    check("rst_byteenable", 32'(mem_byteenable_a), 0);

    // Wrap fill (A) and linear fill (B), zero wait
    next_cycle();
    rd_req = 2'b01; rd_addr[31:0] = 32'h0000_1008;
    @(negedge clk);
    check("wrap_arb_busy", 32'(busy_a), 0);
    check("wrap_arb_read", 32'(mem_read_a), 0);
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      @(negedge clk);
      idx = 32'((2 + k) % 4);
      exp_addr = 32'h1000 + idx * 4;
      check("wrap_read", 32'(mem_read_a), 1);
      check("wrap_be", 32'(mem_byteenable_a), 32'hF);
      check("wrap_addr", mem_address_a, exp_addr);
      check("wrap_valid", 32'(rd_valid_a), 32'h1);
      check("wrap_word", 32'(rd_word_a), idx);
      check("wrap_data", rd_data_a, exp_addr ^ RDX);
      check("wrap_last", 32'(rd_last_a), (k == 3) ? 1 : 0);
      check("lin0_addr", mem_address_b, 32'h1000 + 32'(k) * 4);
      check("lin0_word", 32'(rd_word_b), 32'(k));
      if (k == 3) rd_req = '0;
    end
    next_cycle();
    @(negedge clk);
    check("wrap_done_busy", 32'(busy_a), 0);
    check("lin0_done_busy", 32'(busy_b), 0);

    // Linear fill (B) with two wait cycles per word
    do_reset();
    rd_req = 2'b01; rd_addr[31:0] = 32'h0000_1008; waitrequest = 1'b1;
    @(negedge clk);
    check("lin_arb_read", 32'(mem_read_b), 0);
    for (int k = 0; k < 4; k++) begin
      for (int w = 0; w < 3; w++) begin
        next_cycle();
        waitrequest = (w < 2);
        @(negedge clk);
        check("lin_read_held", 32'(mem_read_b), 1);
        check("lin_addr", mem_address_b, 32'h1000 + 32'(k) * 4);
        check("lin_valid", 32'(rd_valid_b), (w == 2) ? 1 : 0);
        if (w == 2) begin
          check("lin_word", 32'(rd_word_b), 32'(k));
          check("lin_last", 32'(rd_last_b), (k == 3) ? 1 : 0);
        end
      end
      if (k == 3) rd_req = '0;
    end
    next_cycle();
    waitrequest = 1'b0;
    @(negedge clk);
    check("lin_done_read", 32'(mem_read_b), 0);

    // RAW ordering: pending write holds off the data channel
    do_reset();
    ack0 = ack_cnt;
    wr_req = 1'b1; wb_level = 4'd1; wr_addr = 32'h3000; wr_data = 32'hCAFE_BABE;
    wr_byteenable = 4'b0011; rd_req = 2'b10; rd_addr[63:32] = 32'h2000;
    @(negedge clk);
    check("raw_arb_busy", 32'(busy_a), 0);
    next_cycle();
    @(negedge clk);
    check("raw_write", 32'(mem_write_a), 1);
    check("raw_no_read", 32'(mem_read_a), 0);
    check("raw_waddr", mem_address_a, 32'h3000);
    check("raw_wdata", mem_writedata_a, 32'hCAFE_BABE);
    check("raw_wbe", 32'(mem_byteenable_a), 32'h3);
    check("raw_ack", 32'(wr_ack_a), 1);
    next_cycle();
    wr_req = 1'b0; wb_level = '0;
    @(negedge clk);
    check("raw_idle_write", 32'(mem_write_a), 0);
    check("raw_idle_ack", 32'(wr_ack_a), 0);
    next_cycle();
    @(negedge clk);
    check("raw_fill_read", 32'(mem_read_a), 1);
    check("raw_fill_valid", 32'(rd_valid_a), 32'h2);
    check("raw_fill_addr", mem_address_a, 32'h2000);
    for (int k = 1; k < 4; k++) begin
      next_cycle();
      @(negedge clk);
      if (k == 3) rd_req = '0;
    end
    next_cycle();
    @(negedge clk);
    check("raw_ack_count", 32'(ack_cnt - ack0), 1);

    // High water: write beats the instruction fill at level 6
    do_reset();
    wr_req = 1'b1; wb_level = 4'd6; rd_req = 2'b01; rd_addr[31:0] = 32'h1000;
    wr_addr = 32'h4000; wr_data = 32'h1234_5678; wr_byteenable = 4'b1111;
    @(negedge clk);
    next_cycle();
    @(negedge clk);
    check("hw6_write", 32'(mem_write_a), 1);
    check("hw6_no_read", 32'(mem_read_a), 0);
    next_cycle();
    wr_req = 1'b0; wb_level = '0;
    @(negedge clk);
    next_cycle();
    @(negedge clk);
    check("hw6_fill_valid", 32'(rd_valid_a), 32'h1);
    for (int k = 1; k < 4; k++) begin
      next_cycle();
      @(negedge clk);
      if (k == 3) rd_req = '0;
    end

    // Below high water the instruction fill goes first
    do_reset();
    wr_req = 1'b1; wb_level = 4'd5; rd_req = 2'b01; rd_addr[31:0] = 32'h1000;
    @(negedge clk);
    next_cycle();
    @(negedge clk);
    check("hw5_read", 32'(mem_read_a), 1);
    check("hw5_no_write", 32'(mem_write_a), 0);
    check("hw5_valid", 32'(rd_valid_a), 32'h1);
    for (int k = 1; k < 4; k++) begin
      next_cycle();
      @(negedge clk);
      if (k == 3) rd_req = '0;
    end
    next_cycle();
    @(negedge clk);
    next_cycle();
    @(negedge clk);
    check("hw5_then_write", 32'(mem_write_a), 1);
    next_cycle();
    wr_req = 1'b0; wb_level = '0;

    // Round-robin (B) alternates; fixed priority (A) always picks channel 0
    do_reset();
    rd_req = 2'b11; rd_addr[31:0] = 32'h1000; rd_addr[63:32] = 32'h2000;
    for (int f = 0; f < 4; f++) begin
      @(negedge clk);
      check("rr_arb_busy", 32'(busy_b), 0);
      for (int k = 0; k < 4; k++) begin
        next_cycle();
        @(negedge clk);
        if (k == 0) begin
          check("rr_grant", 32'(rd_valid_b), (f % 2 == 0) ? 32'h1 : 32'h2);
          check("fixed_grant", 32'(rd_valid_a), 32'h1);
        end
      end
      next_cycle();
    end
    rd_req = '0;

    // Reset mid-fill aborts without rd_last or wr_ack
    do_reset();
    ack0 = ack_cnt; last0 = last_cnt;
    rd_req = 2'b01; rd_addr[31:0] = 32'h1000;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      next_cycle();
      @(negedge clk);
      check("abort_pre_valid", 32'(rd_valid_a), 32'h1);
    end
    #1;
    rst = 1'b0; rd_req = '0;
    next_cycle();
    @(negedge clk);
    check("abort_read", 32'(mem_read_a), 0);
    check("abort_busy", 32'(busy_a), 0);
    check("abort_valid", 32'(rd_valid_a), 0);
    check("abort_last", 32'(rd_last_a), 0);
    check("abort_last_cnt", 32'(last_cnt - last0), 0);
    check("abort_ack_cnt", 32'(ack_cnt - ack0), 0);
    rst = 1'b1;
    next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mips_mem_arbiter.md
Name: mips_mem_arbiter

Overview:
- Parametrised successor to the single-word Harvard-to-Avalon cache controller. Arbitrates NUM_RD read channels (line-refill requests from the instruction and data caches) and one write-buffer drain channel onto a single Avalon master.
- Adds multi-word line refills with optional critical-word-first wrap, selectable fixed or round-robin read priority, and a write-buffer high-water override.
- Sits between the cache and write-buffer instances and the memory bus.

Parameters:
- NUM_RD, 2, number of read channels; channel 0 is instruction, channel 1 is data.
- LINE_WORDS, 4, 32-bit words per refill; power of two, 1..16.
- WRAP_FILL, 1, 1 = critical word first with wrap inside the line; 0 = fill from word 0.
- RR_MODE, 0, 0 = fixed priority (lowest index wins); 1 = round-robin.
- WB_DEPTH, 8, write-buffer depth; sets the width of wb_level.
- WB_HIGH_WATER, 6, wb_level at or above this value makes writes win arbitration.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low.
- rd_req  in  NUM_RD  line-refill request per channel; held until that channel's rd_last.
- rd_addr  in  32*NUM_RD  byte address of the missed word; channel i occupies bits [32i+31:32i].
- rd_valid  out  NUM_RD  one-cycle pulse per returned word, on the granted channel only.
- rd_data  out  32  returned word, valid while any rd_valid bit is set.
- rd_word  out  $clog2(LINE_WORDS)  word index within the line of rd_data.
- rd_last  out  1  coincides with the final rd_valid of a refill.
- wr_req  in  1  write buffer is non-empty.
- wr_addr  in  32  head-entry address.
- wr_data  in  32  head-entry data.
- wr_byteenable  in  4  head-entry byte enables.
- wb_level  in  $clog2(WB_DEPTH+1)  current occupancy of the write buffer.
- wr_ack  out  1  one-cycle pop strobe when the head write completes.
- mem_address  out  32  Avalon address.
- mem_read  out  1  Avalon read.
- mem_write  out  1  Avalon write.
- mem_writedata  out  32  Avalon write data.
- mem_byteenable  out  4  Avalon byte enables.
- waitrequest  in  1  Avalon waitrequest.
- mem_readdata  in  32  Avalon read data, valid on a read cycle with waitrequest low.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset (rst=0 at a clk edge):
  - state=IDLE; rr_ptr=0; word count=0.
  - mem_read, mem_write, rd_valid, rd_last, wr_ack, busy all 0.
  - mem_address, mem_writedata and rd_data are 0; mem_byteenable=4'b0000.
  - Reset mid-transaction aborts it immediately. No rd_valid or wr_ack is produced for the aborted transaction, and the write-buffer entry is not popped.
- State machine: IDLE, FILL, WRITE.
- IDLE arbitration, evaluated every cycle:
  1. Writes win when wr_req=1 and wb_level>=WB_HIGH_WATER. → WRITE.
  2. Otherwise, if any rd_req is set, a read channel wins. Selection by fixed priority or by round-robin starting at rr_ptr. The winner is latched as g, along with its address. → FILL.
  3. Otherwise, if wr_req=1 → WRITE.
  - Ordering rule: the data channel (index 1) is not eligible while wr_req=1. This prevents a read-after-write hazard, so the buffer drains first. The instruction channel is unaffected.
- Leaving IDLE takes one cycle. The bus strobe rises on the first cycle in FILL or WRITE.
- FILL:
  - Line base = addr with its low $clog2(LINE_WORDS)+2 bits cleared. Start index s = addr[..:2] if WRAP_FILL, else 0.
  - Word k (k = 0..LINE_WORDS-1) is read at address base + ((s+k) mod LINE_WORDS)*4.
  - mem_read=1 and mem_byteenable=4'b1111 throughout FILL.
  - On each cycle with waitrequest=0:
    - rd_valid[g] pulses; rd_data = mem_readdata; rd_word = (s+k) mod LINE_WORDS.
    - k increments; the address advances on the next cycle.
  - After word LINE_WORDS-1: rd_last=1 in the same cycle, mem_read drops, → IDLE.
  - In round-robin mode, rr_ptr becomes (g+1) mod NUM_RD.
  - Zero-wait memory gives one word per cycle. A line therefore costs LINE_WORDS+1 cycles including the arbitration cycle.
- WRITE:
  - mem_write=1; address, data and byteenable are driven straight from the wr_* inputs.
  - mem_write is held until a cycle with waitrequest=0.
  - In that cycle: wr_ack=1, mem_write drops next cycle, → IDLE. Exactly one word is written per WRITE visit, so re-arbitration happens between every pair of writes.
- Protocol rules:
  - rd_req dropping mid-FILL is a requester protocol violation; the fill completes regardless.
  - wr_* inputs must stay stable while mem_write=1.
  - mem_read and mem_write are never high in the same cycle.
- Simultaneous events in IDLE:
  - rd_req and wr_req both set, below high water, data channel requesting: the instruction channel wins if it is requesting; otherwise the write wins.
  - rd_req and wr_req both set, below high water, data channel not requesting: the read wins.

Decomposition:
- Shared package mips_mem_pkg:
  - state_t enum (IDLE=2'd0, FILL=2'd1, WRITE=2'd2).
  - Channel index constants CH_INSTR=0 and CH_DATA=1.
  - Priority-mode constants.
- Sub-module mips_rr_arbiter:
  - Parametrised by N and RR_MODE.
  - Inputs: req vector, ptr, enable mask.
  - Outputs: one-hot grant and its binary index.

Test Plan:
- Wrap fill: LINE_WORDS=4, WRAP_FILL=1, zero wait, rd_req[0]=1, addr 0x1008 → reads at 0x1008, 0x100C, 0x1000, 0x1004; rd_word sequence 2,3,0,1; rd_last with the 4th word; total 5 cycles.
- Linear fill: WRAP_FILL=0, addr 0x1008, waitrequest high for 2 cycles on each word → reads start at 0x1000; each rd_valid follows the 3rd cycle of its word; mem_read never drops early.
- RAW ordering: wr_req=1 with wb_level=1, plus rd_req[1]=1 → WRITE first with wr_ack=1 once; then FILL for channel 1 after wr_req falls.
- High water: WB_HIGH_WATER=6, wb_level=6, rd_req[0]=1 → WRITE is granted before the instruction fill; with wb_level=5 the fill is granted first.
- Round-robin: RR_MODE=1, both rd_req held, wr_req=0 → grants alternate 0,1,0,1 across four line fills.
- Reset mid-fill: rst=0 after 2 words → next cycle mem_read=0, state IDLE, no rd_last; wr_ack count unchanged.
